// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, carry chain split into STAGES registered chunks.
// Define ADD_SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic                 stall;
  logic [STAGES-1:0]    vld_q, vld_d;
  logic [STAGES-1:0]    carry_q, carry_d;
  logic [WIDTH-1:0]     a_q   [STAGES];
  logic [WIDTH-1:0]     a_d   [STAGES];
  logic [WIDTH-1:0]     b_q   [STAGES];
  logic [WIDTH-1:0]     b_d   [STAGES];
  logic [WIDTH-1:0]     res_q [STAGES];
  logic [WIDTH-1:0]     res_d [STAGES];

  logic [WIDTH-1:0]     src_a [STAGES];
  logic [WIDTH-1:0]     src_b [STAGES];
  logic [WIDTH-1:0]     src_r [STAGES];
  logic [STAGES-1:0]    src_c;
  logic [STAGES-1:0]    src_v;
  logic [CW:0]          chunk [STAGES];

  // Global stall: the whole pipe freezes while the output beat is refused.
  always_comb begin
    stall = vld_q[STAGES-1] && !out_ready;
  end

  assign in_ready = !stall;

  // Stage inputs: stage 0 from the ports (b and cin pre-inverted for subtract), others from skew regs.
  always_comb begin
    src_a[0] = a;
    src_b[0] = b ^ {WIDTH{sub}};
    src_c[0] = cin ^ sub;
    src_r[0] = '0;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = carry_q[k-1];
      src_r[k] = res_q[k-1];
      src_v[k] = vld_q[k-1];
    end
  end

  // Per-stage chunk add; data registers only load on a valid beat so bubbles leave them untouched.
  always_comb begin
    vld_d   = vld_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
               + {{CW{1'b0}}, src_c[k]};
      if (!stall) begin
        vld_d[k] = src_v[k];
        if (src_v[k]) begin
          a_d[k]              = src_a[k];
          b_d[k]              = src_b[k];
          res_d[k]            = src_r[k];
          res_d[k][k*CW +: CW] = chunk[k][CW-1:0];
          carry_d[k]          = chunk[k][CW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      vld_q   <= vld_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];

`ifdef ADD_SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Signed overflow uses the effective (possibly inverted) b operand.
  always_comb begin
    ovf_d = ovf_q;
    if (!stall && src_v[STAGES-1]) begin
      ovf_d = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1]) &&
              (res_d[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub: directed vectors, stall, random traffic, mid-flight reset.
module tb_pipelined_add_sub;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADD_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADD_SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         e_mon;
  int           total = 0;
  int           bad = 0;
  int           n_push = 0;
  int           n_out = 0;
  logic         held = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_cout;
  bit           done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    logic [W:0]   full;
    logic [W-1:0] eb;
    exp_t         e;
    eb   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, eb} + (W+1)'(ci ^ sb);
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.o  = (x[W-1] == eb[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  // Output monitor: pops on every transfer and checks that stalled outputs hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (held) begin
        chk("hold_sum", 32'(sum), 32'(held_sum));
        chk("hold_cout", 32'(cout), 32'(held_cout));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 32'(sum), 32'hFFFF_FFFF);
        end else begin
          e_mon = sb_q.pop_front();
          chk("sum", 32'(sum), 32'(e_mon.s));
          chk("cout", 32'(cout), 32'(e_mon.c));
`ifdef ADD_SUB_OVERFLOW_EN
          chk("ovf", 32'(ovf), 32'(e_mon.o));
`endif
        end
        n_out++;
      end
      held      = out_valid && !out_ready;
      held_sum  = sum;
      held_cout = cout;
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb, input bit push);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc && push) begin
        sb_q.push_back(model(x, y, ci, sb));
        n_push++;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Carry crossing the chunk boundary, plus first-beat latency.
    send(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(S));
    drain();

    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
    send(8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
    send(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    send(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    drain();

    // Back-to-back beats with a three-cycle output stall on the first result.
    fork
      begin
        send(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        send(8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
        send(8'h03, 8'h03, 1'b0, 1'b0, 1'b1);
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_sum", 32'(sum), 32'h02);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with bubbles and random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Two beats in flight when reset hits: neither may ever be delivered.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    chk("queue_empty", 32'(sb_q.size()), 32'd0);
    chk("out_count", 32'(n_out), 32'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
